// File: rtl/alu_pkg.sv
// Opcodes, datapath widths and controller states for the shared-ALU arbiter.
// Imported by the interface, the arbiter top and the bench.
package alu_pkg;

    localparam int OPND_W   = 32;
    localparam int RESULT_W = 33;
    localparam int OPC_W    = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h5;
    localparam logic [OPC_W-1:0] OP_SLL = 4'h6;
    localparam logic [OPC_W-1:0] OP_SRL = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Opcodes outside ADD..SRL still go to the ALU but are flagged back to the requester.
    function automatic logic opcode_invalid(input logic [OPC_W-1:0] opc);
        return (opc < OP_ADD) || (opc > OP_SRL);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// master = requesters, response consumer and ALU; slave = the arbiter.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import alu_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OPND_W-1:0] req_operand1;
    logic [NUM_REQ*OPND_W-1:0] req_operand2;
    logic [NUM_REQ*OPC_W-1:0]  req_opcode;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [RESULT_W-1:0]       rsp_result;
    logic                      rsp_err;

    logic [OPND_W-1:0]         alu_operand1;
    logic [OPND_W-1:0]         alu_operand2;
    logic [OPC_W-1:0]          alu_opcode;
    logic [RESULT_W-1:0]       alu_result;

    logic                      busy;

    modport master (
        output req_valid, req_operand1, req_operand2, req_opcode, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               alu_operand1, alu_operand2, alu_opcode, busy
    );

    modport slave (
        input  req_valid, req_operand1, req_operand2, req_opcode, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               alu_operand1, alu_operand2, alu_opcode, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr (mod NUM_REQ) wins.
// Zero latency; grant is all-zero when no request is raised.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] cand;
    logic            hit;

    // Walk from the farthest candidate to the nearest so the nearest hit is written last.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        hit      = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                hit      = 1'b1;
                grant_id = cand;
            end
        end
        if (hit) begin
            grant = NUM_REQ'(1) << grant_id;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters, one operation in flight, round-robin.
// Response ALU_LATENCY+1 edges after accept; requests are held off until the response is taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    alu_arbiter_if.slave  bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;

    logic [OPND_W-1:0]  sel_op1;
    logic [OPND_W-1:0]  sel_op2;
    logic [OPC_W-1:0]   sel_opc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req      (bus.req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign accept = (state == ST_IDLE) && (|grant);

    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        sel_opc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_op1 = bus.req_operand1[OPND_W*i +: OPND_W];
                sel_op2 = bus.req_operand2[OPND_W*i +: OPND_W];
                sel_opc = bus.req_opcode[OPC_W*i +: OPC_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|grant)            state_nxt = ST_EXEC;
            ST_EXEC: if (cnt == '0)         state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready)     state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            ST_IDLE: bus.req_ready = grant;
            ST_EXEC: bus.busy      = 1'b1;
            ST_RESP: begin
                bus.busy      = 1'b1;
                bus.rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // rsp_id/rsp_err are known at accept; rsp_result only once the ALU latency has elapsed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr              <= ID_W'(NUM_REQ - 1);
            cnt              <= '0;
            bus.alu_operand1 <= '0;
            bus.alu_operand2 <= '0;
            bus.alu_opcode   <= '0;
            bus.rsp_id       <= '0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_result   <= '0;
        end else begin
            if (accept) begin
                bus.alu_operand1 <= sel_op1;
                bus.alu_operand2 <= sel_op2;
                bus.alu_opcode   <= sel_opc;
                bus.rsp_id       <= grant_id;
                bus.rsp_err      <= opcode_invalid(sel_opc);
                ptr              <= grant_id;
                cnt              <= CNT_W'(ALU_LATENCY);
            end
            if (state == ST_EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    bus.rsp_result <= bus.alu_result;
                end
            end
        end
    end

    a_grant_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(bus.req_ready));

    a_rsp_hold: assert property (@(posedge clock) disable iff (!reset_n)
        (bus.rsp_valid && !bus.rsp_ready) |=>
            (bus.rsp_valid && $stable(bus.rsp_result) && $stable(bus.rsp_id) && $stable(bus.rsp_err)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered ALU model, per-cycle reference model and directed scenarios.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ    = 4;
    localparam int ALU_LAT = 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    alu_arbiter_if #(.NUM_REQ(NREQ)) bus();

    alu_arbiter #(.NUM_REQ(NREQ), .ALU_LATENCY(ALU_LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [32:0] w;
        w = '0;
        case (op)
            4'h1: return {1'b0, a} + {1'b0, b};
            4'h2: return {1'b0, a} - {1'b0, b};
            4'h3: return {1'b0, a & b};
            4'h4: return {1'b0, a | b};
            4'h5: return {1'b0, a ^ b};
            4'h6: return {1'b0, a} << b[4:0];
            4'h7: begin
                w = {a, 1'b0} >> b[4:0];
                return {w[0], w[32:1]};
            end
            default: return '0;
        endcase
    endfunction

    // Registered single-cycle ALU shared by the arbiter.
    always @(posedge clock) bus.alu_result <= alu_ref(bus.alu_operand1, bus.alu_operand2, bus.alu_opcode);

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Nearest valid requester after the last one served, counting forward around the ring.
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            d = (j - last - 1 + NREQ) % NREQ;
            if (v[j] && d < bestd) begin
                bestd = d;
                best  = j;
            end
        end
        return best;
    endfunction

    int          acc_id[$];
    int          acc_cyc[$];
    int          rise_cyc[$];
    int          hs_cyc[$];
    int          r_id[$];
    logic [32:0] r_res[$];
    int          r_err[$];

    int          m_state;
    int          m_ptr;
    int          m_wait;
    logic [31:0] m_op1, m_op2;
    logic [3:0]  m_opc;
    logic [32:0] m_res, m_rres;
    logic [1:0]  m_rid;
    logic        m_rerr;
    logic        prev_rv;

    always @(negedge clock) begin
        logic [NREQ-1:0] exp_rdy;
        int w;
        if (!reset_n) begin
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_result", bus.rsp_result, 0);
            chk("rst_rsp_err", bus.rsp_err, 0);
            chk("rst_alu_operand1", bus.alu_operand1, 0);
            chk("rst_alu_opcode", bus.alu_opcode, 0);
            m_state = 0; m_ptr = NREQ - 1; m_wait = 0;
            m_op1 = '0; m_op2 = '0; m_opc = '0;
            m_res = '0; m_rres = '0; m_rid = '0; m_rerr = 1'b0;
            prev_rv = 1'b0;
        end else begin
            w = (m_state == 0) ? pick(bus.req_valid, m_ptr) : -1;
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("busy", bus.busy, m_state != 0);
            chk("rsp_valid", bus.rsp_valid, m_state == 2);
            chk("rsp_id", bus.rsp_id, m_rid);
            chk("rsp_result", bus.rsp_result, m_rres);
            chk("rsp_err", bus.rsp_err, m_rerr);
            chk("alu_operand1", bus.alu_operand1, m_op1);
            chk("alu_operand2", bus.alu_operand2, m_op2);
            chk("alu_opcode", bus.alu_opcode, m_opc);

            for (int j = 0; j < NREQ; j++) begin
                if (bus.req_valid[j] && bus.req_ready[j]) begin
                    acc_id.push_back(j);
                    acc_cyc.push_back(cyc + 1);
                end
            end
            if (bus.rsp_valid && !prev_rv) begin
                rise_cyc.push_back(cyc);
                r_id.push_back(int'(bus.rsp_id));
                r_res.push_back(bus.rsp_result);
                r_err.push_back(int'(bus.rsp_err));
            end
            if (bus.rsp_valid && bus.rsp_ready) hs_cyc.push_back(cyc + 1);
            prev_rv = bus.rsp_valid;

            case (m_state)
                0: if (w >= 0) begin
                    m_op1  = bus.req_operand1[32*w +: 32];
                    m_op2  = bus.req_operand2[32*w +: 32];
                    m_opc  = bus.req_opcode[4*w +: 4];
                    m_res  = alu_ref(m_op1, m_op2, m_opc);
                    m_rid  = 2'(w);
                    m_rerr = (m_opc == 4'h0) || (m_opc > 4'h7);
                    m_ptr  = w;
                    m_wait = ALU_LAT + 1;
                    m_state = 1;
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_state = 2;
                        m_rres  = m_res;
                    end
                end
                default: if (bus.rsp_ready) m_state = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.req_operand1[32*id +: 32] = a;
        bus.req_operand2[32*id +: 32] = b;
        bus.req_opcode[4*id +: 4]     = op;
        bus.req_valid[id]             = 1'b1;
    endtask

    task automatic run_accepts(input int n, input bit drop);
        int base;
        int seen;
        int budget;
        base   = acc_id.size();
        seen   = base;
        budget = 200;
        while (acc_id.size() < base + n && budget > 0) begin
            step();
            while (seen < acc_id.size()) begin
                if (drop) bus.req_valid[acc_id[seen]] = 1'b0;
                seen++;
            end
            budget--;
        end
        chk("accept_timeout", acc_id.size(), base + n);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 50;
        while ((bus.busy || bus.rsp_valid) && budget > 0) begin
            step();
            budget--;
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0, r0, h0;
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};
        bus.req_valid    = '0;
        bus.req_operand1 = '0;
        bus.req_operand2 = '0;
        bus.req_opcode   = '0;
        bus.rsp_ready    = 1'b1;
        reset_n          = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // 1: single ADD with carry out
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_idle_rsp_valid", bus.rsp_valid, 0);
        chk("t1_idle_ready", bus.req_ready, 0);
        n0 = acc_id.size(); r0 = rise_cyc.size();
        set_req(0, 32'hFFFF_FFFF, 32'h1, OP_ADD);
        run_accepts(1, 1'b1);
        wait_idle();
        chk("t1_grant_id", acc_id[n0], 0);
        chk("t1_latency", rise_cyc[r0] - acc_cyc[n0], 2);
        chk("t1_rsp_id", r_id[r0], 0);
        chk("t1_rsp_result", r_res[r0], 33'h1_0000_0000);
        chk("t1_rsp_err", r_err[r0], 0);

        // 2: all four requesters continuously valid
        do_reset();
        n0 = acc_id.size(); r0 = rise_cyc.size();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'd10, 32'd3, OP_SUB);
        run_accepts(5, 1'b0);
        bus.req_valid = '0;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            chk("t2_grant_order", acc_id[n0+i], exp_ord[i]);
            chk("t2_rsp_result", r_res[r0+i], 33'd7);
        end
        for (int i = 0; i < 4; i++) chk("t2_issue_interval", acc_cyc[n0+i+1] - acc_cyc[n0+i], 4);

        // 3: response backpressure
        n0 = acc_id.size(); r0 = rise_cyc.size(); h0 = hs_cyc.size();
        bus.rsp_ready = 1'b0;
        set_req(2, 32'h1, 32'd4, OP_SLL);
        run_accepts(1, 1'b1);
        for (int b = 0; b < 20 && !bus.rsp_valid; b++) step();
        chk("t3_rsp_timeout", bus.rsp_valid, 1);
        set_req(0, 32'd5, 32'd6, OP_ADD);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", bus.rsp_valid, 1);
            chk("t3_hold_result", bus.rsp_result, 33'h10);
            chk("t3_hold_id", bus.rsp_id, 2);
            chk("t3_hold_ready", bus.req_ready, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        run_accepts(1, 1'b1);
        wait_idle();
        chk("t3_resume_gap", acc_cyc[n0+1] - hs_cyc[h0], 1);
        chk("t3_resume_id", acc_id[n0+1], 0);
        chk("t3_next_result", r_res[r0+1], 33'd11);

        // 4: invalid opcode, then a normal op
        r0 = rise_cyc.size();
        set_req(3, 32'h1234, 32'h5678, 4'hF);
        run_accepts(1, 1'b1);
        wait_idle();
        set_req(1, 32'hF0F0, 32'h0FF0, OP_XOR);
        run_accepts(1, 1'b1);
        wait_idle();
        chk("t4_bad_err", r_err[r0], 1);
        chk("t4_bad_result", r_res[r0], 0);
        chk("t4_bad_id", r_id[r0], 3);
        chk("t4_next_err", r_err[r0+1], 0);
        chk("t4_next_result", r_res[r0+1], 33'hFF00);
        chk("t4_next_id", r_id[r0+1], 1);

        // 5: reset during EXEC
        set_req(2, 32'hFF00_FF00, 32'h0FF0_0FF0, OP_AND);
        run_accepts(1, 1'b1);
        r0 = rise_cyc.size();
        chk("t5_busy_before", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", bus.rsp_valid, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_alu_operand1", bus.alu_operand1, 0);
        chk("t5_rst_rsp_id", bus.rsp_id, 0);
        step();
        step();
        reset_n = 1'b1;
        repeat (4) step();
        chk("t5_no_response", rise_cyc.size(), r0);
        n0 = acc_id.size();
        for (int i = 0; i < NREQ; i++) set_req(i, i, i, OP_ADD);
        run_accepts(1, 1'b0);
        bus.req_valid = '0;
        wait_idle();
        chk("t5_first_grant", acc_id[n0], 0);

        // 6: pointer fairness
        n0 = acc_id.size(); r0 = rise_cyc.size();
        set_req(1, 32'd1, 32'd2, OP_ADD);
        run_accepts(1, 1'b1);
        wait_idle();
        set_req(1, 32'd4, 32'd4, OP_ADD);
        set_req(3, 32'hF0, 32'h0F, OP_OR);
        run_accepts(2, 1'b1);
        wait_idle();
        chk("t6_first", acc_id[n0], 1);
        chk("t6_second", acc_id[n0+1], 3);
        chk("t6_third", acc_id[n0+2], 1);
        chk("t6_or_result", r_res[r0+1], 33'hFF);
        chk("t6_add_result", r_res[r0+2], 33'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
